mdu_iterative: RTL and testbench

- Iterative multiply/divide unit implementing the RV32M operations (MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU) for the EX stage.
- Parametrised successor to the single-cycle Add/XOR/AND/OR units: generalised to width XLEN, multi-cycle, with a start/busy/valid handshake and pipeline-flush abort.
- The EX stage stalls the pipeline while BUSY is high and captures RESULT on the cycle VALID is high.

---
 rtl/mdu_iterative.sv | 155 +++++++++++++++
 tb/tb_mdu_iterative.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/mdu_iterative.sv
// Iterative RV32M multiply/divide unit: shift-add multiply, restoring divide, one bit per cycle.
// Optional MDU_EARLY_OUT_EN: multiplies finish once the remaining multiplier bits are all zero.
module mdu_iterative #(
  parameter  int XLEN  = 32,
  localparam int CNT_W = $clog2(XLEN) + 1
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            start,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] data1,
  input  logic [XLEN-1:0] data2,
  input  logic            flush,
  output logic            busy,
  output logic            valid,
  output logic [XLEN-1:0] result
);

  // state  | meaning
  // S_IDLE | waiting for start
  // S_CALC | one multiply/divide iteration per cycle
  // S_DONE | result valid for one cycle; may relaunch
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_CALC = 2'd1, S_DONE = 2'd2} state_t;

  localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

  state_t            state, state_nx;
  logic [2:0]        op;
  logic [CNT_W-1:0]  cnt;
  logic [2*XLEN-1:0] acc, acc_nx, mcand, prod;
  logic [XLEN-1:0]   opb, mag_a, mag_b, special_res, final_res, quo, rem;
  logic [XLEN:0]     shifted, diff;
  logic              neg_a, neg_b, in_neg_a, in_neg_b, sgn_a, sgn_b;
  logic              accept, div_zero, div_ovf, is_special, last;

  always_comb begin
    accept      = (state != S_CALC) && start && !flush;
    sgn_a       = 1'b0;
    sgn_b       = 1'b0;
    if (funct3[2]) begin
      sgn_a = !funct3[0];
      sgn_b = !funct3[0];
    end else begin
      sgn_a = (funct3[1:0] == 2'b01) || (funct3[1:0] == 2'b10);
      sgn_b = (funct3[1:0] == 2'b01);
    end
    in_neg_a    = sgn_a && data1[XLEN-1];
    in_neg_b    = sgn_b && data2[XLEN-1];
    mag_a       = in_neg_a ? -data1 : data1;
    mag_b       = in_neg_b ? -data2 : data2;
    div_zero    = funct3[2] && (data2 == '0);
    div_ovf     = funct3[2] && !funct3[0] && (data1 == MOST_NEG) && (data2 == '1);
    is_special  = div_zero || div_ovf;
    special_res = '0;
    if (div_zero)
      special_res = funct3[1] ? data1 : '1;
    else if (div_ovf)
      special_res = funct3[1] ? '0 : data1;
  end

  // Divide keeps {remainder, dividend/quotient} in acc; multiply accumulates the product there.
  always_comb begin
    shifted = acc[2*XLEN-1:XLEN-1];
    diff    = shifted - {1'b0, opb};
    acc_nx  = acc;
    if (op[2]) begin
      if (!diff[XLEN])
        acc_nx = {diff[XLEN-1:0], acc[XLEN-2:0], 1'b1};
      else
        acc_nx = {acc[2*XLEN-2:0], 1'b0};
    end else if (opb[0]) begin
      acc_nx = acc + mcand;
    end
    prod = (neg_a ^ neg_b) ? -acc_nx : acc_nx;
    quo  = acc_nx[XLEN-1:0];
    rem  = acc_nx[2*XLEN-1:XLEN];
    if (!op[2])
      final_res = (op[1:0] == 2'b00) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
    else if (op[1])
      final_res = neg_a ? -rem : rem;
    else
      final_res = (neg_a ^ neg_b) ? -quo : quo;
    last = (cnt == CNT_W'(1));
`ifdef MDU_EARLY_OUT_EN
    if (!op[2] && (opb[XLEN-1:1] == '0))
      last = 1'b1;
`endif
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      S_IDLE, S_DONE: begin
        if (accept)
          state_nx = is_special ? S_DONE : S_CALC;
        else
          state_nx = S_IDLE;
      end
      S_CALC:  if (last) state_nx = S_DONE;
      default: state_nx = S_IDLE;
    endcase
    if (flush)
      state_nx = S_IDLE;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      state <= S_IDLE;
    else
      state <= state_nx;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      op     <= '0;
      cnt    <= '0;
      acc    <= '0;
      mcand  <= '0;
      opb    <= '0;
      neg_a  <= 1'b0;
      neg_b  <= 1'b0;
      result <= '0;
    end else if (!flush) begin
      if (accept) begin
        op    <= funct3;
        cnt   <= CNT_W'(XLEN);
        opb   <= mag_b;
        neg_a <= in_neg_a;
        neg_b <= in_neg_b;
        if (funct3[2]) begin
          acc   <= {{XLEN{1'b0}}, mag_a};
          mcand <= '0;
        end else begin
          acc   <= '0;
          mcand <= {{XLEN{1'b0}}, mag_a};
        end
        if (is_special)
          result <= special_res;
      end else if (state == S_CALC) begin
        cnt <= cnt - CNT_W'(1);
        acc <= acc_nx;
        if (!op[2]) begin
          mcand <= mcand << 1;
          opb   <= opb >> 1;
        end
        if (last)
          result <= final_res;
      end
    end
  end

  assign busy  = (state == S_CALC);
  assign valid = (state == S_DONE);

endmodule

// File: tb/tb_mdu_iterative.sv
// Directed self-checking bench for mdu_iterative; latency expectations follow MDU_EARLY_OUT_EN.
module tb_mdu_iterative;

  localparam int XLEN = 32;
`ifdef MDU_EARLY_OUT_EN
  localparam int LAT_MUL53    = 3;
  localparam int LAT_MULZERO  = 2;
  localparam int LAT_MULHSU2  = 3;
`else
  localparam int LAT_MUL53    = 33;
  localparam int LAT_MULZERO  = 33;
  localparam int LAT_MULHSU2  = 33;
`endif

  logic            clk = 1'b0;
  logic            reset_n;
  logic            start;
  logic [2:0]      funct3;
  logic [XLEN-1:0] data1, data2;
  logic            flush;
  logic            busy, valid;
  logic [XLEN-1:0] result;

  int checks   = 0;
  int failures = 0;
  int lat, bcnt, vseen;

  mdu_iterative #(.XLEN(XLEN)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .funct3(funct3),
    .data1(data1), .data2(data2), .flush(flush),
    .busy(busy), .valid(valid), .result(result)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Called #1 after an edge; returns #1 after the start edge.
  task automatic launch(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    funct3 = f3;
    data1  = a;
    data2  = b;
    start  = 1'b1;
    @(posedge clk);
    #1;
    start  = 1'b0;
  endtask

  // lat = edges from start edge to the edge at which valid is first seen; 0 on timeout.
  task automatic wait_valid(output int l, output int bc);
    l  = 0;
    bc = 0;
    for (int m = 0; m < 100; m++) begin
      if (busy) bc++;
      if (valid) begin
        l = m + 1;
        break;
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_op(input string tag, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] exp_res,
                       input int exp_lat, input int exp_busy);
    launch(f3, a, b);
    wait_valid(lat, bcnt);
    check({tag, "_result"}, result, exp_res);
    check({tag, "_latency"}, 32'(lat), 32'(exp_lat));
    check({tag, "_busy_cycles"}, 32'(bcnt), 32'(exp_busy));
  endtask

  initial begin
    reset_n = 1'b0;
    start   = 1'b0;
    flush   = 1'b0;
    funct3  = 3'b000;
    data1   = '0;
    data2   = '0;
    #23;
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_valid", {31'd0, valid}, 32'd0);
    check("reset_result", result, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;

    do_op("mul_7_m3", 3'b000, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 33, 32);
    @(posedge clk);
    #1;
    check("valid_one_cycle", {31'd0, valid}, 32'd0);
    check("result_held", result, 32'hFFFF_FFEB);

    do_op("mulh_min_min", 3'b001, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 33, 32);
    do_op("mulhu_max_max", 3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33, 32);
    do_op("mulhsu_m1_2", 3'b010, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFF, LAT_MULHSU2, LAT_MULHSU2 - 1);
    do_op("div_m7_2", 3'b100, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 33, 32);
    do_op("rem_m7_2", 3'b110, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 33, 32);
    do_op("divu_100_7", 3'b101, 32'd100, 32'd7, 32'd14, 33, 32);
    do_op("remu_100_7", 3'b111, 32'd100, 32'd7, 32'd2, 33, 32);

    // Flush on the tenth CALC cycle of a divide
    @(posedge clk);
    #1;
    launch(3'b100, 32'd1000, 32'd3);
    repeat (9) begin
      @(posedge clk);
      #1;
    end
    check("flush_pre_busy", {31'd0, busy}, 32'd1);
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    check("flush_busy", {31'd0, busy}, 32'd0);
    check("flush_valid", {31'd0, valid}, 32'd0);
    vseen = 0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (valid) vseen++;
    end
    check("flush_no_valid", 32'(vseen), 32'd0);
    check("flush_result_kept", result, 32'd2);

    // Flush wins over a simultaneous start
    funct3 = 3'b100;
    data1  = 32'd5;
    data2  = 32'd0;
    start  = 1'b1;
    flush  = 1'b1;
    @(posedge clk);
    #1;
    start  = 1'b0;
    flush  = 1'b0;
    check("flush_over_start_valid", {31'd0, valid}, 32'd0);
    check("flush_over_start_result", result, 32'd2);

    // Asynchronous reset mid-multiply
    launch(3'b000, 32'd7, 32'd3);
    repeat (5) begin
      @(posedge clk);
      #1;
    end
    check("pre_reset_busy", {31'd0, busy}, 32'd1);
    #2;
    reset_n = 1'b0;
    #1;
    check("midreset_busy", {31'd0, busy}, 32'd0);
    check("midreset_valid", {31'd0, valid}, 32'd0);
    check("midreset_result", result, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;

    do_op("div_5_0", 3'b100, 32'd5, 32'd0, 32'hFFFF_FFFF, 1, 0);
    do_op("rem_5_0", 3'b110, 32'd5, 32'd0, 32'd5, 1, 0);
    do_op("divu_5_0", 3'b101, 32'd5, 32'd0, 32'hFFFF_FFFF, 1, 0);
    do_op("div_ovf", 3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1, 0);
    do_op("rem_ovf", 3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1, 0);

    do_op("mul_9_0", 3'b000, 32'd9, 32'd0, 32'd0, LAT_MULZERO, LAT_MULZERO - 1);

    // Back-to-back: start accepted in the DONE cycle
    @(posedge clk);
    #1;
    do_op("mul_5_3", 3'b000, 32'd5, 32'd3, 32'd15, LAT_MUL53, LAT_MUL53 - 1);
    launch(3'b101, 32'd100, 32'd7);
    check("b2b_busy_no_gap", {31'd0, busy}, 32'd1);
    check("b2b_result_held", result, 32'd15);
    wait_valid(lat, bcnt);
    check("b2b_divu_result", result, 32'd14);
    check("b2b_divu_latency", 32'(lat), 32'd33);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
